// File: rtl/delay_capture.sv
// Measures clk cycles from a trigger rising edge to the falling edge of an
// active-low delayed output, returning one saturating count per trigger over valid/ready.
`timescale 1ns/1ps

module delay_capture #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   trigger_in,
  input  logic                   delay_out_n,
  output logic [COUNT_WIDTH-1:0] meas_count,
  output logic                   meas_overflow,
  output logic                   meas_valid,
  input  logic                   meas_ready,
  output logic                   busy,
  output logic                   abort,
  output logic                   missed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   meas_count_q, meas_count_d;
  logic                     meas_overflow_q, meas_overflow_d;
  logic                     meas_valid_q, meas_valid_d;
  logic                     abort_q, abort_d;
  logic                     missed_q, missed_d;
  logic                     trig_q, dout_q;
  logic                     rise, fall;

  // Saturating increment; the COUNT branch stops at CNT_MAX before this matters.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  always_comb begin
    rise = trigger_in & ~trig_q;
    fall = ~delay_out_n & dout_q;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    meas_count_d    = meas_count_q;
    meas_overflow_d = meas_overflow_q;
    meas_valid_d    = meas_valid_q;
    abort_d         = 1'b0;
    missed_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A fall coinciding with the starting rise belongs to an earlier event.
        if (rise && enable) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_COUNT: begin
        if (!enable || !trigger_in) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (fall) begin
          state_d         = ST_HOLD;
          meas_count_d    = cnt_q;
          meas_overflow_d = 1'b0;
          meas_valid_d    = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d         = ST_HOLD;
          meas_count_d    = CNT_MAX;
          meas_overflow_d = 1'b1;
          meas_valid_d    = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_HOLD: begin
        // Edges arriving while a result is pending are dropped, even on the handshake cycle.
        if (rise) begin
          missed_d = 1'b1;
        end
        if (meas_valid_q && meas_ready) begin
          state_d      = ST_IDLE;
          meas_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      meas_count_q    <= '0;
      meas_overflow_q <= 1'b0;
      meas_valid_q    <= 1'b0;
      abort_q         <= 1'b0;
      missed_q        <= 1'b0;
      trig_q          <= 1'b0;
      dout_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      meas_count_q    <= meas_count_d;
      meas_overflow_q <= meas_overflow_d;
      meas_valid_q    <= meas_valid_d;
      abort_q         <= abort_d;
      missed_q        <= missed_d;
      trig_q          <= trigger_in;
      dout_q          <= delay_out_n;
    end
  end

  assign meas_count    = meas_count_q;
  assign meas_overflow = meas_overflow_q;
  assign meas_valid    = meas_valid_q;
  assign busy          = (state_q == ST_COUNT);
  assign abort         = abort_q;
  assign missed        = missed_q;

endmodule

// File: tb/tb_delay_capture.sv
// Directed bench for delay_capture: per-cycle vector table plus hand sequences
// for overflow, back-pressure and mid-count reset.
`timescale 1ns/1ps

module tb_delay_capture;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          en, trg, dn, rdy;
  logic [CW-1:0] meas_count;
  logic          meas_overflow, meas_valid, busy, abort, missed;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          en, trg, dn, rdy;
    logic [CW-1:0] cnt;
    logic          vld, ovf, bsy, abt, mis;
  } vec_t;

  vec_t tbl[$];

  delay_capture #(.COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en),
    .trigger_in   (trg),
    .delay_out_n  (dn),
    .meas_count   (meas_count),
    .meas_overflow(meas_overflow),
    .meas_valid   (meas_valid),
    .meas_ready   (rdy),
    .busy         (busy),
    .abort        (abort),
    .missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void add(input logic e, t, d, r, input logic [CW-1:0] c,
                              input logic v, o, b, a, m);
    vec_t x;
    x.en = e; x.trg = t; x.dn = d; x.rdy = r;
    x.cnt = c; x.vld = v; x.ovf = o; x.bsy = b; x.abt = a; x.mis = m;
    tbl.push_back(x);
  endfunction

  // full=1 also checks count/overflow when no result is valid (reset state).
  task automatic check(input string nm, input logic full, input logic [CW-1:0] c,
                       input logic v, o, b, a, m);
    logic [3:0] got_f, exp_f;
    logic       ok;
    got_f = {meas_valid, busy, abort, missed};
    exp_f = {v, b, a, m};
    ok = (got_f === exp_f);
    if (v || full) ok = ok && (meas_count === c) && (meas_overflow === o);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d ovf=%b vld=%b busy=%b abort=%b missed=%b, want cnt=%0d ovf=%b vld=%b busy=%b abort=%b missed=%b",
               nm, meas_count, meas_overflow, meas_valid, busy, abort, missed,
               c, o, v, b, a, m);
    end
  endtask

  task automatic step(input string nm, input logic e, t, d, r, input logic [CW-1:0] c,
                      input logic v, o, b, a, m);
    en = e; trg = t; dn = d; rdy = r;
    @(posedge clk);
    #1;
    check(nm, 1'b0, c, v, o, b, a, m);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trg = 1'b0; dn = 1'b1; rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b1, 4'd0, 0, 0, 0, 0, 0);
    en = 1'b1;
    rst_n = 1'b1;

    add(1,0,1,1, 0, 0,0,0,0,0);
    add(0,1,1,1, 0, 0,0,0,0,0);
    add(0,0,1,1, 0, 0,0,0,0,0);
    // basic: fall sampled 10 edges after the rise
    add(1,1,1,1, 0, 0,0,1,0,0);
    for (int i = 0; i < 9; i++) add(1,1,1,1, 0, 0,0,1,0,0);
    add(1,1,0,1, 10, 1,0,0,0,0);
    add(1,1,0,1, 0, 0,0,0,0,0);
    add(1,0,1,1, 0, 0,0,0,0,0);
    // trigger drop aborts, then a 7-cycle measurement
    for (int i = 0; i < 4; i++) add(1,1,1,1, 0, 0,0,1,0,0);
    add(1,0,1,1, 0, 0,0,0,1,0);
    add(1,0,1,1, 0, 0,0,0,0,0);
    for (int i = 0; i < 7; i++) add(1,1,1,1, 0, 0,0,1,0,0);
    add(1,1,0,1, 7, 1,0,0,0,0);
    add(1,0,1,1, 0, 0,0,0,0,0);
    // enable drop aborts; trigger still high gives no new rise
    add(1,1,1,1, 0, 0,0,1,0,0);
    add(0,1,1,1, 0, 0,0,0,1,0);
    add(1,1,1,1, 0, 0,0,0,0,0);
    add(1,0,1,1, 0, 0,0,0,0,0);
    // fall together with rise is ignored
    add(1,1,0,1, 0, 0,0,1,0,0);
    add(1,1,0,1, 0, 0,0,1,0,0);
    add(1,1,1,1, 0, 0,0,1,0,0);
    add(1,1,0,1, 3, 1,0,0,0,0);
    add(1,0,1,1, 0, 0,0,0,0,0);
    // minimum delay of one cycle
    add(1,1,1,1, 0, 0,0,1,0,0);
    add(1,1,0,1, 1, 1,0,0,0,0);
    add(1,0,1,1, 0, 0,0,0,0,0);

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].trg, tbl[i].dn, tbl[i].rdy,
           tbl[i].cnt, tbl[i].vld, tbl[i].ovf, tbl[i].bsy, tbl[i].abt, tbl[i].mis);
    end

    // overflow: counter saturates at 15
    step("ovf_start", 1,1,1,1, 0, 0,0,1,0,0);
    for (int i = 0; i < 14; i++) step($sformatf("ovf_cnt%0d", i), 1,1,1,1, 0, 0,0,1,0,0);
    step("ovf_result", 1,1,1,1, 15, 1,1,0,0,0);
    step("ovf_accept", 1,0,1,1, 0, 0,0,0,0,0);

    // back-pressure: result held, rises in HOLD reported as missed
    step("bp_start", 1,1,1,0, 0, 0,0,1,0,0);
    for (int i = 0; i < 9; i++) step($sformatf("bp_cnt%0d", i), 1,1,1,0, 0, 0,0,1,0,0);
    step("bp_result", 1,1,0,0, 10, 1,0,0,0,0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("bp_hold%0d", i), 1, (i == 0) ? 1'b0 : 1'b1, 1, 0,
           10, 1,0,0,0, (i == 1) ? 1'b1 : 1'b0);
    end
    step("bp_prep", 0,0,1,0, 10, 1,0,0,0,0);
    step("bp_handshake_rise", 1,1,1,1, 0, 0,0,0,0,1);
    step("bp_idle", 1,1,1,1, 0, 0,0,0,0,0);
    step("bp_idle2", 1,0,1,1, 0, 0,0,0,0,0);

    // asynchronous reset in the middle of a count
    step("rst_start", 1,1,1,1, 0, 0,0,1,0,0);
    for (int i = 0; i < 4; i++) step($sformatf("rst_cnt%0d", i), 1,1,1,1, 0, 0,0,1,0,0);
    #2;
    rst_n = 1'b0;
    trg = 1'b0;
    #1;
    check("rst_async", 1'b1, 4'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rst_held", 1'b1, 4'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("post_rst_start", 1,1,1,1, 0, 0,0,1,0,0);
    step("post_rst_c1", 1,1,1,1, 0, 0,0,1,0,0);
    step("post_rst_c2", 1,1,1,1, 0, 0,0,1,0,0);
    step("post_rst_result", 1,1,0,1, 3, 1,0,0,0,0);
    step("post_rst_accept", 1,0,1,1, 0, 0,0,0,0,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
